// File: rtl/vga_reader_pkg.sv
// Shared constants, FSM state type and width helpers for the VGA frame reader.
package vga_reader_pkg;
  localparam int PIX_PER_WORD = 4;
  localparam int PIX_W        = 8;

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  // Bits needed to hold every value 0..n inclusive.
  function automatic int count_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

  // Bits needed to index n items (0..n-1).
  function automatic int index_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/vga_word_fifo.sv
// First-word fall-through FIFO of 32-bit frame-buffer words.
module vga_word_fifo
  import vga_reader_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      push,
  input  logic                      pop,
  input  logic [31:0]               din,
  output logic [31:0]               dout,
  output logic [count_w(DEPTH)-1:0] count
);
  localparam int AW = index_w(DEPTH);
  localparam int CW = count_w(DEPTH);

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != CW'(DEPTH)) || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/vga_frame_reader.sv
// Avalon-MM read master that scans a 32-bit frame buffer and streams it out
// as 8-bit pixels with start/end-of-frame markers.
module vga_frame_reader
  import vga_reader_pkg::*;
#(
  parameter int BASE_WORD   = 0,
  parameter int FRAME_WORDS = 19200,
  parameter int FIFO_DEPTH  = 8,
  parameter int ADDR_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_chipselect,
  output logic              avm_read,
  output logic [3:0]        avm_byteenable,
  input  logic [31:0]       avm_readdata,
  output logic [PIX_W-1:0]  pix_data,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic              pix_sop,
  output logic              pix_eop,
  output logic              frame_done,
  output logic              underflow
);
  localparam int IW  = count_w(FRAME_WORDS);
  localparam int OW  = index_w(FRAME_WORDS);
  localparam int CW  = count_w(FIFO_DEPTH);
  localparam int CW1 = CW + 1;
  localparam int PIW = index_w(PIX_PER_WORD);
  localparam logic [ADDR_W-1:0] FIRST_ADDR = ADDR_W'(BASE_WORD);
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(BASE_WORD + FRAME_WORDS - 1);
  localparam logic [IW-1:0]     ALL_ISSUED = IW'(FRAME_WORDS);
  localparam logic [OW-1:0]     LAST_WORD  = OW'(FRAME_WORDS - 1);
  localparam logic [PIW-1:0]    LAST_PIX   = PIW'(PIX_PER_WORD - 1);

  state_t         state;
  logic [IW-1:0]  issued;
  logic [IW-1:0]  issued_next;
  logic           rd_pending;
  logic [OW-1:0]  out_word;
  logic [PIW-1:0] pix_idx;
  logic           started;
  logic [31:0]    head;
  logic [CW-1:0]  fifo_count;
  logic [CW1-1:0] occ_next;
  logic           push;
  logic           pop;
  logic           accept;
  logic           eop_accept;
  logic           credit_ok;

  vga_word_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (avm_readdata),
    .dout  (head),
    .count (fifo_count)
  );

  assign avm_chipselect = avm_read;
  assign avm_byteenable = 4'hF;
  assign push           = rd_pending;

  assign pix_valid  = (fifo_count != '0);
  assign pix_data   = pix_valid ? head[{pix_idx, 3'b000} +: PIX_W] : '0;
  assign pix_sop    = pix_valid && (pix_idx == '0) && (out_word == '0);
  assign pix_eop    = pix_valid && (pix_idx == LAST_PIX) && (out_word == LAST_WORD);
  assign accept     = pix_valid && pix_ready;
  assign pop        = accept && (pix_idx == LAST_PIX);
  assign eop_accept = accept && pix_eop;
  assign frame_done = eop_accept;

  // avm_read is registered, so the credit test looks one cycle ahead: the
  // occupancy after this edge plus the read now in flight must leave a slot.
  always_comb begin
    occ_next    = CW1'(fifo_count) + CW1'(push) - CW1'(pop);
    credit_ok   = (occ_next + CW1'(avm_read)) < CW1'(FIFO_DEPTH);
    issued_next = issued + IW'(avm_read);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      issued      <= '0;
      avm_address <= FIRST_ADDR;
      avm_read    <= 1'b0;
    end else begin
      if (avm_read)
        avm_address <= (avm_address == LAST_ADDR) ? FIRST_ADDR : avm_address + ADDR_W'(1);
      case (state)
        IDLE: begin
          if (enable) begin
            state       <= FETCH;
            issued      <= '0;
            avm_address <= FIRST_ADDR;
            avm_read    <= credit_ok;
          end
        end
        FETCH: begin
          issued <= issued_next;
          if (issued_next == ALL_ISSUED) begin
            state    <= DRAIN;
            avm_read <= 1'b0;
          end else begin
            avm_read <= credit_ok;
          end
        end
        DRAIN: begin
          if (eop_accept) begin
            if (enable) begin
              state       <= FETCH;
              issued      <= '0;
              avm_address <= FIRST_ADDR;
              avm_read    <= credit_ok;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: begin
          state    <= IDLE;
          avm_read <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_pending <= 1'b0;
      pix_idx    <= '0;
      out_word   <= '0;
      started    <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      rd_pending <= avm_read;
      if (accept) begin
        pix_idx <= pix_idx + PIW'(1);
        if (pop) out_word <= (out_word == LAST_WORD) ? '0 : out_word + OW'(1);
      end
      if (eop_accept)
        started <= 1'b0;
      else if (accept && pix_sop)
        started <= 1'b1;
      if (pix_ready && !pix_valid && (state == FETCH) && started)
        underflow <= 1'b1;
    end
  end
endmodule

// File: tb/tb_vga_frame_reader.sv
// Directed bench for vga_frame_reader: 16-word frame placed at the top of the
// 16-bit address space so the address wrap at FFFF is exercised.
module tb_vga_frame_reader;
  localparam logic [15:0] BASE  = 16'hFFF0;
  localparam int          FW    = 16;
  localparam int          DEPTH = 8;
  localparam int          NPIX  = FW * 4;

  logic        clk;
  logic        reset;
  logic        enable;
  logic [15:0] avm_address;
  logic        avm_chipselect;
  logic        avm_read;
  logic [3:0]  avm_byteenable;
  logic [31:0] avm_readdata;
  logic [7:0]  pix_data;
  logic        pix_valid;
  logic        pix_ready;
  logic        pix_sop;
  logic        pix_eop;
  logic        frame_done;
  logic        underflow;

  int          checks = 0;
  int          errors = 0;
  int          exp_p = 0;
  int          acc_pix = 0;
  int          reads_issued = 0;
  logic [15:0] addr_log[$];

  bit          acc;
  logic        o_v;
  logic [7:0]  o_d;
  logic        o_s;
  logic        o_e;
  logic        o_fd;

  vga_frame_reader #(
    .BASE_WORD   (32'hFFF0),
    .FRAME_WORDS (FW),
    .FIFO_DEPTH  (DEPTH),
    .ADDR_W      (16)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .enable         (enable),
    .avm_address    (avm_address),
    .avm_chipselect (avm_chipselect),
    .avm_read       (avm_read),
    .avm_byteenable (avm_byteenable),
    .avm_readdata   (avm_readdata),
    .pix_data       (pix_data),
    .pix_valid      (pix_valid),
    .pix_ready      (pix_ready),
    .pix_sop        (pix_sop),
    .pix_eop        (pix_eop),
    .frame_done     (frame_done),
    .underflow      (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Frame-buffer word k holds {k,k,k,k} + 03020100.
  function automatic logic [31:0] mem_word(input logic [15:0] a);
    logic [7:0] k;
    k = 8'(a - BASE);
    return {k, k, k, k} + 32'h03020100;
  endfunction

  // Pixel p of a frame is byte (p%4) of word (p/4) = (p/4) + (p%4).
  function automatic logic [7:0] exp_data(input int p);
    return 8'((p >> 2) + (p & 3));
  endfunction

  always @(posedge clk) begin
    avm_readdata <= (avm_read && avm_chipselect) ? mem_word(avm_address) : 32'hA5A5A5A5;
  end

  always @(negedge clk) begin
    if (avm_read) begin
      reads_issued++;
      addr_log.push_back(avm_address);
    end
  end

  task automatic clear_counters();
    exp_p = 0;
    acc_pix = 0;
    reads_issued = 0;
    addr_log.delete();
  endtask

  task automatic step(input bit r);
    @(negedge clk);
    pix_ready = r;
    #1;
    o_v  = pix_valid;
    o_d  = pix_data;
    o_s  = pix_sop;
    o_e  = pix_eop;
    o_fd = frame_done;
    acc  = pix_valid && r;
    if (acc) acc_pix++;
  endtask

  task automatic test_reset();
    int bad = 0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (avm_read !== 1'b0 || avm_chipselect !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_read got rd=%b cs=%b want 0 0", avm_read, avm_chipselect);
    end
    checks++;
    if (avm_byteenable !== 4'hF) begin
      errors++; $display("[TB] FAIL reset_be got %h want f", avm_byteenable);
    end
    checks++;
    if (avm_address !== BASE) begin
      errors++; $display("[TB] FAIL reset_addr got %h want %h", avm_address, BASE);
    end
    checks++;
    if ({pix_valid, pix_sop, pix_eop, frame_done, pix_data} !== 12'h000) begin
      errors++; $display("[TB] FAIL reset_pix got v=%b s=%b e=%b fd=%b d=%h want all 0",
                         pix_valid, pix_sop, pix_eop, frame_done, pix_data);
    end
    checks++;
    if (underflow !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_underflow got %b want 0", underflow);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (5) begin
      step(1'b0);
      if (avm_read !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("[TB] FAIL idle_no_read got %0d read cycles want 0", bad);
    end
  endtask

  task automatic test_enable_drop();
    int cyc = 0;
    int bad = 0;
    clear_counters();
    enable = 1'b1;
    while (acc_pix < NPIX && cyc < 1000) begin
      step(1'b1);
      cyc++;
      if (acc) begin
        if (acc_pix == 1) enable = 1'b0;
        checks++;
        if (o_d !== exp_data(exp_p) || o_s !== (exp_p == 0) || o_e !== (exp_p == NPIX-1) || o_fd !== (exp_p == NPIX-1)) begin
          errors++; $display("[TB] FAIL drop_stream p=%0d got d=%h s=%b e=%b fd=%b want d=%h s=%b e=%b",
                             exp_p, o_d, o_s, o_e, o_fd, exp_data(exp_p), exp_p == 0, exp_p == NPIX-1);
        end
        exp_p = (exp_p + 1) % NPIX;
      end
    end
    checks++;
    if (acc_pix != NPIX) begin
      errors++; $display("[TB] FAIL drop_timeout got %0d pixels want %0d", acc_pix, NPIX);
    end
    checks++;
    if (reads_issued != FW) begin
      errors++; $display("[TB] FAIL drop_reads got %0d want %0d", reads_issued, FW);
    end
    foreach (addr_log[i]) begin
      checks++;
      if (addr_log[i] !== BASE + 16'(i)) begin
        errors++; $display("[TB] FAIL drop_addr i=%0d got %h want %h", i, addr_log[i], BASE + 16'(i));
      end
    end
    repeat (100) begin
      step(1'b1);
      if (avm_read !== 1'b0 || pix_valid !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("[TB] FAIL drop_idle got %0d active cycles want 0", bad);
    end
  endtask

  task automatic test_stall();
    int cyc = 0;
    int unstable = 0;
    int over = 0;
    logic [7:0] held_d;
    logic held_s;
    logic held_e;
    clear_counters();
    enable = 1'b1;
    while (acc_pix < 10 && cyc < 200) begin
      step(1'b1);
      cyc++;
      if (acc) begin
        if (acc_pix == 1) enable = 1'b0;
        checks++;
        if (o_d !== exp_data(exp_p) || o_s !== (exp_p == 0) || o_e !== 1'b0) begin
          errors++; $display("[TB] FAIL stall_pre p=%0d got d=%h s=%b e=%b want d=%h", exp_p, o_d, o_s, o_e, exp_data(exp_p));
        end
        exp_p = exp_p + 1;
      end
    end
    step(1'b0);
    held_d = o_d;
    held_s = o_s;
    held_e = o_e;
    checks++;
    if (o_v !== 1'b1 || o_d !== exp_data(exp_p)) begin
      errors++; $display("[TB] FAIL stall_head got v=%b d=%h want v=1 d=%h", o_v, o_d, exp_data(exp_p));
    end
    repeat (49) begin
      step(1'b0);
      if (o_v !== 1'b1 || o_d !== held_d || o_s !== held_s || o_e !== held_e) unstable++;
      if (reads_issued - acc_pix / 4 > DEPTH) over++;
    end
    checks++;
    if (unstable != 0) begin
      errors++; $display("[TB] FAIL stall_stable got %0d changed cycles want 0", unstable);
    end
    checks++;
    if (over != 0) begin
      errors++; $display("[TB] FAIL stall_credit got %0d overrun cycles want 0", over);
    end
    checks++;
    if (avm_read !== 1'b0 || reads_issued - acc_pix / 4 != DEPTH) begin
      errors++; $display("[TB] FAIL stall_full got rd=%b buffered=%0d want rd=0 buffered=%0d",
                         avm_read, reads_issued - acc_pix / 4, DEPTH);
    end
    cyc = 0;
    while (acc_pix < NPIX && cyc < 1000) begin
      step(1'b1);
      cyc++;
      if (acc) begin
        checks++;
        if (o_d !== exp_data(exp_p) || o_s !== (exp_p == 0) || o_e !== (exp_p == NPIX-1) || o_fd !== (exp_p == NPIX-1)) begin
          errors++; $display("[TB] FAIL stall_stream p=%0d got d=%h s=%b e=%b fd=%b want d=%h",
                             exp_p, o_d, o_s, o_e, o_fd, exp_data(exp_p));
        end
        exp_p = (exp_p + 1) % NPIX;
      end
    end
    checks++;
    if (acc_pix != NPIX || reads_issued != FW) begin
      errors++; $display("[TB] FAIL stall_end got pix=%0d reads=%0d want %0d %0d", acc_pix, reads_issued, NPIX, FW);
    end
  endtask

  task automatic test_back_to_back();
    int cyc = 0;
    int eop_cyc = 0;
    int gap;
    clear_counters();
    enable = 1'b1;
    while (acc_pix < 2 * NPIX && cyc < 2000) begin
      step(1'b1);
      cyc++;
      if (acc) begin
        if (acc_pix == NPIX + 1) begin
          enable = 1'b0;
          gap = cyc - eop_cyc - 1;
          checks++;
          if (gap > 2) begin
            errors++; $display("[TB] FAIL b2b_gap got %0d idle cycles want <= 2", gap);
          end
        end
        if (exp_p == NPIX - 1) eop_cyc = cyc;
        checks++;
        if (o_d !== exp_data(exp_p) || o_s !== (exp_p == 0) || o_e !== (exp_p == NPIX-1) || o_fd !== (exp_p == NPIX-1)) begin
          errors++; $display("[TB] FAIL b2b_stream p=%0d got d=%h s=%b e=%b fd=%b want d=%h",
                             exp_p, o_d, o_s, o_e, o_fd, exp_data(exp_p));
        end
        exp_p = (exp_p + 1) % NPIX;
      end
    end
    checks++;
    if (acc_pix != 2 * NPIX || reads_issued != 2 * FW) begin
      errors++; $display("[TB] FAIL b2b_end got pix=%0d reads=%0d want %0d %0d", acc_pix, reads_issued, 2 * NPIX, 2 * FW);
    end
    foreach (addr_log[i]) begin
      checks++;
      if (addr_log[i] !== BASE + 16'(i % FW)) begin
        errors++; $display("[TB] FAIL b2b_addr i=%0d got %h want %h", i, addr_log[i], BASE + 16'(i % FW));
      end
    end
    checks++;
    if (underflow !== 1'b0) begin
      errors++; $display("[TB] FAIL b2b_underflow got %b want 0", underflow);
    end
  endtask

  task automatic test_reset_mid_frame();
    int cyc = 0;
    clear_counters();
    enable = 1'b1;
    while (acc_pix < 6 && cyc < 200) begin
      step(1'b1);
      cyc++;
    end
    #1 reset = 1'b1;
    #1;
    checks++;
    if ({avm_read, avm_chipselect, pix_valid, pix_sop, pix_eop, frame_done, underflow} !== 7'b0 ||
        avm_address !== BASE || pix_data !== 8'h00) begin
      errors++; $display("[TB] FAIL async_reset got rd=%b v=%b addr=%h d=%h want 0 0 %h 00",
                         avm_read, pix_valid, avm_address, pix_data, BASE);
    end
    repeat (2) @(negedge clk);
    clear_counters();
    reset = 1'b0;
    cyc = 0;
    while (acc_pix < NPIX && cyc < 1000) begin
      step(1'b1);
      cyc++;
      if (acc) begin
        if (acc_pix == 1) enable = 1'b0;
        checks++;
        if (o_d !== exp_data(exp_p) || o_s !== (exp_p == 0) || o_e !== (exp_p == NPIX-1) || o_fd !== (exp_p == NPIX-1)) begin
          errors++; $display("[TB] FAIL rst_stream p=%0d got d=%h s=%b e=%b fd=%b want d=%h",
                             exp_p, o_d, o_s, o_e, o_fd, exp_data(exp_p));
        end
        exp_p = (exp_p + 1) % NPIX;
      end
    end
    checks++;
    if (acc_pix != NPIX || reads_issued != FW) begin
      errors++; $display("[TB] FAIL rst_end got pix=%0d reads=%0d want %0d %0d", acc_pix, reads_issued, NPIX, FW);
    end
  endtask

  task automatic test_random_ready();
    int cyc = 0;
    bit seen = 1'b0;
    bit r;
    clear_counters();
    enable = 1'b1;
    while (acc_pix < 3 * NPIX && cyc < 5000) begin
      r = seen && ($urandom_range(0, 1) == 1);
      step(r);
      cyc++;
      if (o_v) seen = 1'b1;
      if (acc) begin
        if (acc_pix == 2 * NPIX + 1) enable = 1'b0;
        checks++;
        if (o_d !== exp_data(exp_p) || o_s !== (exp_p == 0) || o_e !== (exp_p == NPIX-1) || o_fd !== (exp_p == NPIX-1)) begin
          errors++; $display("[TB] FAIL rand_stream p=%0d got d=%h s=%b e=%b fd=%b want d=%h",
                             exp_p, o_d, o_s, o_e, o_fd, exp_data(exp_p));
        end
        exp_p = (exp_p + 1) % NPIX;
      end
    end
    checks++;
    if (acc_pix != 3 * NPIX || reads_issued != 3 * FW) begin
      errors++; $display("[TB] FAIL rand_end got pix=%0d reads=%0d want %0d %0d", acc_pix, reads_issued, 3 * NPIX, 3 * FW);
    end
    checks++;
    if (underflow !== 1'b0) begin
      errors++; $display("[TB] FAIL rand_underflow got %b want 0", underflow);
    end
  endtask

  initial begin
    reset     = 1'b1;
    enable    = 1'b0;
    pix_ready = 1'b0;
    $display("[TB] start");
    test_reset();
    test_enable_drop();
    test_stall();
    test_back_to_back();
    test_reset_mid_frame();
    test_random_ready();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
